// File: rtl/alien_edge_hit_detector.sv
// ---------------------------------------------------------------------------
// alien_edge_hit_detector
//
// Watches the alien-matrix drawing request during raster scan and records
// which screen borders the matrix touched in the current frame. On each
// startOfFrame the recorded borders are reported for one cycle as a
// collision pulse plus HitEdgeCode. The motion controller uses that report
// to reverse or step the matrix. Left/right reports are masked for
// HOLDOFF_FRAMES reports afterwards so a matrix still overlapping a border
// while turning is not reported twice. A sticky bottom flag feeds game-over
// logic.
//
// Ports:
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse at frame start (frame boundary)
//   playGame            game running; low clears everything synchronously
//   pixelX, pixelY      current raster position, unsigned 11-bit
//   alienDR             alien matrix drawing request for the current pixel
//   collision           one-cycle pulse, at least one edge reported
//   HitEdgeCode         {left, top, right, bottom}, 0 when collision=0
//   alienReachedBottom  sticky, set by a reported bottom hit
//   bboxMinX/MaxX/MaxY  per-frame alien bounding box (optional)
//
// Optional feature: define ALIEN_BBOX_EN to track the per-frame bounding
// box of alien pixels. Without it the bbox outputs are tied to 0.
//
// Debug: fsm_state holds the FSM state (IDLE/ACCUM/REPORT) for probing.
// ---------------------------------------------------------------------------
module alien_edge_hit_detector #(
  parameter logic [10:0] LEFT_LIMIT     = 11'd0,
  parameter logic [10:0] RIGHT_LIMIT    = 11'd639,
  parameter logic [10:0] TOP_LIMIT      = 11'd0,
  parameter logic [10:0] BOTTOM_LIMIT   = 11'd440,
  parameter logic [3:0]  HOLDOFF_FRAMES = 4'd2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        alienDR,
  output logic        collision,
  output logic [3:0]  HitEdgeCode,
  output logic        alienReachedBottom,
  output logic [10:0] bboxMinX,
  output logic [10:0] bboxMaxX,
  output logic [10:0] bboxMaxY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0] fsm_state;
  logic [3:0] seen;        // {left, top, right, bottom} for the current frame
  logic [3:0] left_hold;
  logic [3:0] right_hold;

  logic [3:0] pixel_hits;
  logic [3:0] masked_report;
  logic       frame_start;  // first frame after leaving IDLE
  logic       frame_edge;   // boundary between two accumulated frames

  // Hits of the pixel presented this cycle, same bit order as HitEdgeCode.
  always_comb begin
    pixel_hits = 4'b0000;
    if (alienDR) begin
      pixel_hits[3] = (pixelX <= LEFT_LIMIT);
      pixel_hits[2] = (pixelY <= TOP_LIMIT);
      pixel_hits[1] = (pixelX >= RIGHT_LIMIT);
      pixel_hits[0] = (pixelY >= BOTTOM_LIMIT);
    end
  end

  // Left/right are suppressed while their holdoff counter is still running.
  always_comb begin
    masked_report    = seen;
    masked_report[3] = seen[3] & (left_hold == 4'd0);
    masked_report[1] = seen[1] & (right_hold == 4'd0);
  end

  assign frame_start = playGame && startOfFrame && (fsm_state == IDLE);
  assign frame_edge  = playGame && startOfFrame && (fsm_state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fsm_state          <= IDLE;
      seen               <= 4'b0000;
      left_hold          <= 4'd0;
      right_hold         <= 4'd0;
      collision          <= 1'b0;
      HitEdgeCode        <= 4'b0000;
      alienReachedBottom <= 1'b0;
    end else if (!playGame) begin
      fsm_state          <= IDLE;
      seen               <= 4'b0000;
      left_hold          <= 4'd0;
      right_hold         <= 4'd0;
      collision          <= 1'b0;
      HitEdgeCode        <= 4'b0000;
      alienReachedBottom <= 1'b0;
    end else if (fsm_state == IDLE) begin
      collision   <= 1'b0;
      HitEdgeCode <= 4'b0000;
      if (startOfFrame) begin
        // The pulse cycle's pixel is the first pixel of the new frame.
        seen      <= pixel_hits;
        fsm_state <= ACCUM;
      end
    end else if (startOfFrame) begin
      // Frame boundary: report the finished frame, start the next with
      // this cycle's pixel. Also taken from REPORT for back-to-back pulses.
      collision   <= |masked_report;
      HitEdgeCode <= masked_report;
      seen        <= pixel_hits;
      fsm_state   <= REPORT;
      if (masked_report[3])
        left_hold <= HOLDOFF_FRAMES;
      else if (left_hold != 4'd0)
        left_hold <= left_hold - 4'd1;
      if (masked_report[1])
        right_hold <= HOLDOFF_FRAMES;
      else if (right_hold != 4'd0)
        right_hold <= right_hold - 4'd1;
      if (masked_report[0])
        alienReachedBottom <= 1'b1;
    end else begin
      collision   <= 1'b0;
      HitEdgeCode <= 4'b0000;
      seen        <= seen | pixel_hits;
      fsm_state   <= ACCUM;
    end
  end

`ifdef ALIEN_BBOX_EN
  logic [10:0] acc_min_x;
  logic [10:0] acc_max_x;
  logic [10:0] acc_max_y;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_min_x <= 11'd2047;
      acc_max_x <= 11'd0;
      acc_max_y <= 11'd0;
      bboxMinX  <= 11'd0;
      bboxMaxX  <= 11'd0;
      bboxMaxY  <= 11'd0;
    end else if (!playGame) begin
      acc_min_x <= 11'd2047;
      acc_max_x <= 11'd0;
      acc_max_y <= 11'd0;
      bboxMinX  <= 11'd0;
      bboxMaxX  <= 11'd0;
      bboxMaxY  <= 11'd0;
    end else if (frame_start || frame_edge) begin
      if (frame_edge) begin
        bboxMinX <= acc_min_x;
        bboxMaxX <= acc_max_x;
        bboxMaxY <= acc_max_y;
      end
      // Restart the accumulators seeded with this cycle's pixel.
      acc_min_x <= alienDR ? pixelX : 11'd2047;
      acc_max_x <= alienDR ? pixelX : 11'd0;
      acc_max_y <= alienDR ? pixelY : 11'd0;
    end else if (fsm_state != IDLE && alienDR) begin
      if (pixelX < acc_min_x) acc_min_x <= pixelX;
      if (pixelX > acc_max_x) acc_max_x <= pixelX;
      if (pixelY > acc_max_y) acc_max_y <= pixelY;
    end
  end
`else
  assign bboxMinX = 11'd0;
  assign bboxMaxX = 11'd0;
  assign bboxMaxY = 11'd0;
`endif

endmodule

// File: tb/tb_alien_edge_hit_detector.sv
module tb_alien_edge_hit_detector;

  localparam int HOLD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame, playGame, alienDR;
  logic [10:0] pixelX, pixelY;
  logic collision, alienReachedBottom;
  logic [3:0] HitEdgeCode;
  logic [10:0] bboxMinX, bboxMaxX, bboxMaxY;

  always #5 clk = ~clk;

  alien_edge_hit_detector dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
    .pixelX(pixelX), .pixelY(pixelY), .alienDR(alienDR),
    .collision(collision), .HitEdgeCode(HitEdgeCode),
    .alienReachedBottom(alienReachedBottom),
    .bboxMinX(bboxMinX), .bboxMaxX(bboxMaxX), .bboxMaxY(bboxMaxY)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Frame-level view: borders touched in the current frame, number of
  // reports made, and the report index at which each side last reported.
  bit m_active;
  bit s_l, s_t, s_r, s_b;
  int rc, last_l, last_r;
  int mn_x, mx_x, mx_y;
  logic exp_col, exp_bottom;
  logic [3:0] exp_code;
  logic [10:0] exp_minx, exp_maxx, exp_maxy;

  task automatic model_clear();
    m_active = 0; s_l = 0; s_t = 0; s_r = 0; s_b = 0;
    rc = 0; last_l = -100; last_r = -100;
    mn_x = 2047; mx_x = 0; mx_y = 0;
    exp_col = 0; exp_code = 0; exp_bottom = 0;
    exp_minx = 0; exp_maxx = 0; exp_maxy = 0;
  endtask

  task automatic model_pixel(input logic dr, input int x, input int y);
    if (dr) begin
      if (x <= 0)   s_l = 1;
      if (y <= 0)   s_t = 1;
      if (x >= 639) s_r = 1;
      if (y >= 440) s_b = 1;
      if (x < mn_x) mn_x = x;
      if (x > mx_x) mx_x = x;
      if (y > mx_y) mx_y = y;
    end
  endtask

  task automatic model_new_frame(input logic dr, input int x, input int y);
    s_l = 0; s_t = 0; s_r = 0; s_b = 0;
    mn_x = 2047; mx_x = 0; mx_y = 0;
    model_pixel(dr, x, y);
  endtask

  // Expected outputs after the coming clock edge.
  task automatic model_step(input logic sof, input logic dr, input int x, input int y);
    bit rl, rr;
    if (!playGame) begin
      model_clear();
    end else if (!m_active) begin
      exp_col = 0; exp_code = 0;
      if (sof) begin
        m_active = 1;
        model_new_frame(dr, x, y);
      end
    end else if (sof) begin
      rc++;
      rl = s_l && (rc - last_l > HOLD);
      rr = s_r && (rc - last_r > HOLD);
      if (rl) last_l = rc;
      if (rr) last_r = rc;
      exp_code = {rl, s_t, rr, s_b};
      exp_col  = rl | s_t | rr | s_b;
      if (s_b) exp_bottom = 1;
`ifdef ALIEN_BBOX_EN
      exp_minx = 11'(mn_x); exp_maxx = 11'(mx_x); exp_maxy = 11'(mx_y);
`endif
      model_new_frame(dr, x, y);
    end else begin
      exp_col = 0; exp_code = 0;
      model_pixel(dr, x, y);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic sof, input logic dr, input logic [10:0] x, input logic [10:0] y);
    startOfFrame = sof; alienDR = dr; pixelX = x; pixelY = y;
    model_step(sof, dr, int'(x), int'(y));
    @(posedge clk);
    #1;
  endtask

  // n cycles of interior pixels that never touch a border
  task automatic pad(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 11'($urandom_range(1, 638)), 11'($urandom_range(1, 439)));
  endtask

  task automatic clean_sof();
    cycle(1'b1, 1'b0, 11'd320, 11'd240);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 0; playGame = 0; startOfFrame = 0; alienDR = 0; pixelX = 0; pixelY = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (collision !== 0 || HitEdgeCode !== 0 || alienReachedBottom !== 0 ||
        bboxMinX !== 0 || bboxMaxX !== 0 || bboxMaxY !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got col=%b code=%b bot=%b bbox=%0d/%0d/%0d, want all 0",
               collision, HitEdgeCode, alienReachedBottom, bboxMinX, bboxMaxX, bboxMaxY);
    end
    resetN = 1;
    cycle(1'b0, 1'b0, 11'd0, 11'd0);
  endtask

  task automatic test_no_hit();
    playGame = 1;
    clean_sof();
    cycle(1'b0, 1'b1, 11'd300, 11'd200);
    pad(6);
    clean_sof();
    checks++;
    if (collision !== 1'b0 || HitEdgeCode !== 4'b0000 || alienReachedBottom !== 1'b0) begin
      errors++;
      $display("FAIL no_hit: got col=%b code=%b bot=%b, want 0 0000 0", collision, HitEdgeCode, alienReachedBottom);
    end
  endtask

  task automatic test_left_holdoff();
    logic [3:0] want;
    for (int f = 0; f < 4; f++) begin
      cycle(1'b0, 1'b1, 11'd0, 11'd100);
      pad(5);
      clean_sof();
      want = (f == 0 || f == 3) ? 4'b1000 : 4'b0000;
      checks++;
      if (HitEdgeCode !== want || collision !== (want != 0) || exp_code !== want) begin
        errors++;
        $display("FAIL left_holdoff frame%0d: got col=%b code=%b, want code=%b (model %b)",
                 f, collision, HitEdgeCode, want, exp_code);
      end
      pad(1);
      checks++;
      if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
        errors++;
        $display("FAIL left_pulse_width frame%0d: got col=%b code=%b, want 0 0000", f, collision, HitEdgeCode);
      end
    end
    // let the left holdoff expire
    pad(3); clean_sof(); pad(3); clean_sof();
  endtask

  task automatic test_both_sides();
    cycle(1'b0, 1'b1, 11'd0, 11'd50);
    pad(2);
    cycle(1'b0, 1'b1, 11'd639, 11'd50);
    pad(2);
    clean_sof();
    checks++;
    if (collision !== 1'b1 || HitEdgeCode !== 4'b1010) begin
      errors++;
      $display("FAIL both_sides: got col=%b code=%b, want 1 1010", collision, HitEdgeCode);
    end
  endtask

  task automatic test_bottom_sticky();
    cycle(1'b0, 1'b1, 11'd320, 11'd450);
    pad(3);
    clean_sof();
    checks++;
    if (collision !== 1'b1 || HitEdgeCode !== 4'b0001) begin
      errors++;
      $display("FAIL bottom_code: got col=%b code=%b, want 1 0001", collision, HitEdgeCode);
    end
    for (int f = 0; f < 5; f++) begin
      pad(4);
      clean_sof();
      checks++;
      if (alienReachedBottom !== 1'b1 || collision !== 1'b0) begin
        errors++;
        $display("FAIL bottom_sticky frame%0d: got bot=%b col=%b, want 1 0", f, alienReachedBottom, collision);
      end
    end
    playGame = 0;
    cycle(1'b0, 1'b0, 11'd0, 11'd0);
    checks++;
    if (alienReachedBottom !== 1'b0) begin
      errors++;
      $display("FAIL bottom_clear: got bot=%b, want 0", alienReachedBottom);
    end
  endtask

  task automatic test_abort();
    playGame = 1;
    clean_sof();
    cycle(1'b0, 1'b1, 11'd0, 11'd100);
    pad(3);
    playGame = 0;
    clean_sof();
    checks++;
    if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
      errors++;
      $display("FAIL abort_no_pulse: got col=%b code=%b, want 0 0000", collision, HitEdgeCode);
    end
    pad(2);
    playGame = 1;
    clean_sof();
    pad(4);
    clean_sof();
    checks++;
    if (collision !== 1'b0 || HitEdgeCode !== 4'b0000) begin
      errors++;
      $display("FAIL abort_restart: got col=%b code=%b, want 0 0000", collision, HitEdgeCode);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 11'd0, 11'd0);
    pad(2);
    // boundary whose own pixel (right+bottom) belongs to the new frame
    cycle(1'b1, 1'b1, 11'd639, 11'd440);
    checks++;
    if (collision !== 1'b1 || HitEdgeCode !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_first: got col=%b code=%b, want 1 1100", collision, HitEdgeCode);
    end
    clean_sof();
    checks++;
    if (collision !== 1'b1 || HitEdgeCode !== 4'b0011) begin
      errors++;
      $display("FAIL b2b_second: got col=%b code=%b, want 1 0011", collision, HitEdgeCode);
    end
    pad(1);
    checks++;
    if (collision !== 1'b0 || alienReachedBottom !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after: got col=%b bot=%b, want 0 1", collision, alienReachedBottom);
    end
  endtask

  task automatic test_bbox();
    // start from a fresh game so no holdoff or stale frame interferes
    playGame = 0;
    pad(1);
    playGame = 1;
    clean_sof();
    for (int y = 80; y <= 111; y += 3)
      for (int x = 32; x <= 95; x += 7)
        cycle(1'b0, 1'b1, 11'(x), 11'(y));
    cycle(1'b0, 1'b1, 11'd95, 11'd111);
    cycle(1'b0, 1'b1, 11'd32, 11'd80);
    cycle(1'b0, 1'b0, 11'd1000, 11'd1000);
    clean_sof();
`ifdef ALIEN_BBOX_EN
    checks++;
    if (bboxMinX !== 11'd32 || bboxMaxX !== 11'd95 || bboxMaxY !== 11'd111) begin
      errors++;
      $display("FAIL bbox_box: got %0d/%0d/%0d, want 32/95/111", bboxMinX, bboxMaxX, bboxMaxY);
    end
    repeat (5) cycle(1'b0, 1'b0, 11'd0, 11'd0);
    clean_sof();
    checks++;
    if (bboxMinX !== 11'd2047 || bboxMaxX !== 11'd0 || bboxMaxY !== 11'd0) begin
      errors++;
      $display("FAIL bbox_empty: got %0d/%0d/%0d, want 2047/0/0", bboxMinX, bboxMaxX, bboxMaxY);
    end
`else
    checks++;
    if (bboxMinX !== 11'd0 || bboxMaxX !== 11'd0 || bboxMaxY !== 11'd0) begin
      errors++;
      $display("FAIL bbox_tied: got %0d/%0d/%0d, want 0/0/0", bboxMinX, bboxMaxX, bboxMaxY);
    end
`endif
  endtask

  task automatic test_random();
    logic sof, dr;
    logic [10:0] x, y;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) playGame = ~playGame;
      if (!playGame && $urandom_range(0, 9) == 0) playGame = 1;
      sof = ($urandom_range(0, 29) == 0);
      dr  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: x = 11'd0;
        1: x = 11'd639;
        2: x = 11'($urandom_range(640, 2047));
        default: x = 11'($urandom_range(1, 638));
      endcase
      case ($urandom_range(0, 7))
        0: y = 11'd0;
        1: y = 11'($urandom_range(440, 2047));
        default: y = 11'($urandom_range(1, 439));
      endcase
      cycle(sof, dr, x, y);
      checks++;
      if (collision !== exp_col || HitEdgeCode !== exp_code || alienReachedBottom !== exp_bottom) begin
        errors++;
        $display("FAIL random_edges cyc%0d: got col=%b code=%b bot=%b, want %b %b %b",
                 i, collision, HitEdgeCode, alienReachedBottom, exp_col, exp_code, exp_bottom);
      end
      checks++;
      if (bboxMinX !== exp_minx || bboxMaxX !== exp_maxx || bboxMaxY !== exp_maxy) begin
        errors++;
        $display("FAIL random_bbox cyc%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                 i, bboxMinX, bboxMaxX, bboxMaxY, exp_minx, exp_maxx, exp_maxy);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_no_hit();
    test_left_holdoff();
    test_both_sides();
    test_bottom_sticky();
    test_abort();
    test_back_to_back();
    test_bbox();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
